// File: rtl/led_stretch_bank.sv
// Bank of LED indicator drivers: per-channel stretch/toggle/blink/pass modes.
// Ports: clk125MHz, resetn, evt_in, mode, clr_cnt, cnt_sel -> led, evt_count.
module led_stretch_bank #(
  parameter int CHANNELS     = 8,
  parameter int CNT_W        = 27,
  parameter int HOLD_CYCLES  = 71072000,
  parameter int BLINK_CYCLES = 6250000,
  parameter bit RETRIGGER    = 1'b1,
  parameter int SYNC_STAGES  = 2,
  parameter int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk125MHz,
  input  logic                  resetn,
  input  logic [CHANNELS-1:0]   evt_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic                  clr_cnt,
  input  logic [SEL_W-1:0]      cnt_sel,
  output logic [CHANNELS-1:0]   led,
  output logic [7:0]            evt_count
);

  localparam logic [1:0] M_STRETCH = 2'b00;
  localparam logic [1:0] M_TOGGLE  = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_PASS    = 2'b11;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLK_LD  = CNT_W'(BLINK_CYCLES - 1);
  localparam int               NSEL    = 2 ** SEL_W;

  // Unused select codes read as zero.
  logic [7:0] ecnt [NSEL];
  logic [7:0] evt_count_q;

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   evt_q;
    logic [1:0]             mode_q;
    logic                   act_q, act_d;
    logic                   led_q, led_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       blk_q, blk_d;
    logic [7:0]             ecnt_q, ecnt_d;
    logic [1:0]             mode_c;
    logic                   sync;
    logic                   mchg;
    logic                   win;
    logic                   reload;
    logic                   expire;

    assign mode_c = mode[2*g +: 2];
    assign sync   = sync_q[SYNC_STAGES-1];
    assign mchg   = (mode_q != mode_c);
    assign win    = (mode_c == M_STRETCH) ||
                    (mode_c == M_BLINK);
    // An event in the cnt==0 cycle counts as an
    // active-state event, so it wins over expiry.
    assign reload = evt_q & (!act_q || RETRIGGER);
    assign expire = act_q & (cnt_q == '0) & !reload;

    always_ff @(posedge clk125MHz or negedge resetn) begin
      if (!resetn) begin
        sync_q <= '0;
        prev_q <= 1'b0;
        evt_q  <= 1'b0;
        mode_q <= '0;
        act_q  <= 1'b0;
        led_q  <= 1'b0;
        cnt_q  <= '0;
        blk_q  <= '0;
        ecnt_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], evt_in[g]};
        prev_q <= sync;
        evt_q  <= sync & ~prev_q;
        mode_q <= mode_c;
        act_q  <= act_d;
        led_q  <= led_d;
        cnt_q  <= cnt_d;
        blk_q  <= blk_d;
        ecnt_q <= ecnt_d;
      end
    end

    always_comb begin
      act_d = act_q;
      cnt_d = cnt_q;
      blk_d = blk_q;
      if (mchg || !win || expire) begin
        act_d = 1'b0;
        cnt_d = '0;
        blk_d = '0;
      end else if (reload) begin
        act_d = 1'b1;
        cnt_d = HOLD_LD;
        blk_d = BLK_LD;
      end else if (act_q) begin
        cnt_d = cnt_q - CNT_W'(1);
        blk_d = (blk_q == '0) ? BLK_LD
                              : blk_q - CNT_W'(1);
      end
    end

    always_comb begin
      led_d = led_q;
      if (mchg) begin
        led_d = 1'b0;
      end else begin
        unique case (mode_c)
          M_STRETCH: begin
            if (reload)      led_d = 1'b1;
            else if (expire) led_d = 1'b0;
          end
          M_TOGGLE: begin
            if (evt_q) led_d = ~led_q;
          end
          M_BLINK: begin
            if (reload)      led_d = 1'b1;
            else if (expire) led_d = 1'b0;
            else if (act_q && blk_q == '0)
              led_d = ~led_q;
          end
          // prev_q keeps pass-through latency equal
          // to the event path.
          M_PASS: led_d = prev_q;
        endcase
      end
    end

    always_comb begin
      ecnt_d = ecnt_q;
      if (clr_cnt)
        ecnt_d = {7'd0, evt_q};
      else if (evt_q && ecnt_q != 8'hFF)
        ecnt_d = ecnt_q + 8'd1;
    end

    assign led[g]  = led_q;
    assign ecnt[g] = ecnt_q;
  end

  for (g = CHANNELS; g < NSEL; g++) begin : g_pad
    assign ecnt[g] = '0;
  end

  always_ff @(posedge clk125MHz or negedge resetn) begin
    if (!resetn) evt_count_q <= '0;
    else         evt_count_q <= ecnt[cnt_sel];
  end

  assign evt_count = evt_count_q;

endmodule

// File: tb/tb_led_stretch_bank.sv
// Directed bench for led_stretch_bank: table rows plus
// hand-written multi-cycle sequences.
module tb_led_stretch_bank;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  evt;
  logic [15:0] mode;
  logic        clr;
  logic [3:0]  sel;
  logic [7:0]  led;
  logic [7:0]  ecnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] evt;
    logic       clr;
    logic [3:0] sel;
    int         n;
    logic [7:0] mask;
    logic [7:0] led;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [13];

  led_stretch_bank #(
    .CHANNELS    (8),
    .CNT_W       (27),
    .HOLD_CYCLES (20),
    .BLINK_CYCLES(4),
    .RETRIGGER   (1'b1),
    .SYNC_STAGES (2),
    .SEL_W       (4)
  ) dut (
    .clk125MHz(clk),
    .resetn   (rstn),
    .evt_in   (evt),
    .mode     (mode),
    .clr_cnt  (clr),
    .cnt_sel  (sel),
    .led      (led),
    .evt_count(ecnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  initial begin
    int hi;
    logic [20:0] pat;
    logic quiet;

    // evt, clr, sel, n, mask, led, cnt
    tbl[0]  = '{8'h02, 1'b0, 4'd1, 4, 8'h02, 8'h02, 8'd0};
    tbl[1]  = '{8'h00, 1'b0, 4'd1, 2, 8'h02, 8'h02, 8'd1};
    tbl[2]  = '{8'h02, 1'b0, 4'd1, 5, 8'h02, 8'h00, 8'd2};
    tbl[3]  = '{8'h00, 1'b0, 4'd1, 2, 8'h02, 8'h00, 8'd2};
    tbl[4]  = '{8'h0A, 1'b0, 4'd1, 5, 8'h0A, 8'h0A, 8'd3};
    tbl[5]  = '{8'h08, 1'b0, 4'd3, 3, 8'h0A, 8'h0A, 8'd1};
    tbl[6]  = '{8'h00, 1'b0, 4'd3, 4, 8'h0A, 8'h02, 8'd1};
    tbl[7]  = '{8'h00, 1'b0, 4'd9, 1, 8'h0A, 8'h02, 8'd0};
    tbl[8]  = '{8'h00, 1'b0, 4'd2, 1, 8'h0A, 8'h02, 8'd1};
    tbl[9]  = '{8'h00, 1'b0, 4'd0, 1, 8'h0A, 8'h02, 8'd3};
    tbl[10] = '{8'h00, 1'b1, 4'd0, 1, 8'h0A, 8'h02, 8'd3};
    tbl[11] = '{8'h00, 1'b0, 4'd0, 1, 8'h0A, 8'h02, 8'd0};
    tbl[12] = '{8'h00, 1'b0, 4'd1, 1, 8'h0A, 8'h02, 8'd0};

    // ch0 STRETCH, ch1 TOGGLE, ch2 BLINK, ch3 PASS
    rstn = 1'b0;
    evt  = '0;
    mode = 16'h00E4;
    clr  = 1'b0;
    sel  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", led, 0);
    chk("rst_cnt", ecnt, 0);
    rstn = 1'b1;
    step(4);

    // isolated stretch event
    evt[0] = 1'b1;
    step(3);
    evt[0] = 1'b0;
    chk("str_early", led[0], 0);
    step(1);
    chk("str_rise", led[0], 1);
    hi = 1;
    for (int k = 1; k < 100; k++) begin
      step(1);
      if (led[0]) hi++;
      else break;
    end
    chk("str_len", hi, 20);
    chk("str_cnt", ecnt, 1);
    step(5);

    // retrigger 10 cycles into the window
    evt[0] = 1'b1;
    step(3);
    evt[0] = 1'b0;
    step(1);
    chk("rtg_rise", led[0], 1);
    hi = 1;
    for (int k = 1; k < 100; k++) begin
      if (k == 7)  evt[0] = 1'b1;
      if (k == 10) evt[0] = 1'b0;
      step(1);
      if (led[0]) hi++;
      else break;
    end
    evt[0] = 1'b0;
    chk("rtg_len", hi, 30);
    step(5);

    // blink pattern on ch2
    evt[2] = 1'b1;
    step(3);
    evt[2] = 1'b0;
    step(1);
    pat[0] = led[2];
    for (int j = 1; j < 21; j++) begin
      step(1);
      pat[j] = led[2];
    end
    chk("blink_pat", pat, 21'b0_1111_0000_1111_0000_1111);
    step(3);
    chk("blink_off", led[2], 0);

    // toggle, pass, count select and clear
    for (int i = 0; i < 13; i++) begin
      evt = tbl[i].evt;
      clr = tbl[i].clr;
      sel = tbl[i].sel;
      step(tbl[i].n);
      chk($sformatf("row%0d_led", i),
          led & tbl[i].mask, tbl[i].led);
      chk($sformatf("row%0d_cnt", i),
          ecnt, tbl[i].cnt);
    end
    evt = '0;
    clr = 1'b0;
    step(3);

    // saturation on ch3
    sel = 4'd3;
    for (int i = 0; i < 254; i++) begin
      evt[3] = 1'b1;
      step(2);
      evt[3] = 1'b0;
      step(2);
    end
    step(3);
    chk("sat_254", ecnt, 254);
    for (int i = 0; i < 46; i++) begin
      evt[3] = 1'b1;
      step(2);
      evt[3] = 1'b0;
      step(2);
    end
    step(3);
    chk("sat_255", ecnt, 255);

    // clear coincident with an event
    evt[3] = 1'b1;
    step(3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    evt[3] = 1'b0;
    step(2);
    chk("clr_evt", ecnt, 1);
    step(3);

    // STRETCH -> PASS mid-window on ch0
    sel = 4'd0;
    evt[0] = 1'b1;
    step(3);
    evt[0] = 1'b0;
    step(1);
    chk("mc_start", led[0], 1);
    step(5);
    mode = 16'h00E7;
    step(1);
    chk("mc_clear", led[0], 0);
    chk("mc_other", led[1], 1);
    step(1);
    chk("mc_hold", led[0], 0);
    evt[0] = 1'b1;
    step(4);
    chk("pass_hi", led[0], 1);
    evt[0] = 1'b0;
    step(4);
    chk("pass_lo", led[0], 0);
    mode = 16'h00E4;
    step(3);

    // async reset mid-window
    evt[0] = 1'b1;
    step(3);
    evt[0] = 1'b0;
    step(1);
    chk("rs_start", led[0], 1);
    step(3);
    chk("rs_cnt", ecnt, 3);
    rstn = 1'b0;
    #2;
    chk("rs_led", led, 0);
    chk("rs_ecnt", ecnt, 0);
    rstn = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (led !== 8'h00) quiet = 1'b0;
    end
    chk("rs_quiet", quiet, 1);
    chk("rs_cnt0", ecnt, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
